regfile_mp: RTL and testbench

//   Parametrised multi-port integer register file; successor to the single-write, 2-read core RF.

---
 rtl/rv100_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv100_pkg.sv
// Shared constants for the rv100 integer register file and its scoreboard.
package rv100_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int REG_AW   = $clog2(NREGS);
    localparam int REG_ZERO = 0;

    // Value every architectural register takes on reset.
    localparam logic [XLEN-1:0] RF_RST_VAL = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for multi-cycle producers.
// Priority per register: flush clears, else allocate sets, else writeback clears.
// rs_busy is masked by a same-cycle writeback so a consumer can read the
// bypassed value without stalling.
module rf_scoreboard
    import rv100_pkg::*;
#(
    parameter int  NREGS = rv100_pkg::NREGS,
    parameter int  NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_rd,
    input  logic              flush,
    input  logic [NREGS-1:0]  wr_hit,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]    rs_busy,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;

    // Busy bit update; x0 is held at zero so it can never look pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q[REG_ZERO] <= 1'b0;
            for (int r = 1; r < NREGS; r++) begin
                if (flush)
                    busy_q[r] <= 1'b0;
                else if (alloc_en && alloc_rd == AW'(r))
                    busy_q[r] <= 1'b1;
                else if (wr_hit[r])
                    busy_q[r] <= 1'b0;
            end
        end
    end

    assign busy_vec = busy_q;

    // Same-cycle allocate is for a younger instruction, so it is not visible here.
    for (genvar k = 0; k < NRD; k++) begin : g_rs_busy
        logic [AW-1:0] a;
        assign a          = rs_addr[k*AW +: AW];
        assign rs_busy[k] = busy_q[a] && !wr_hit[a];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports with
// write-through bypass, NWR write ports (higher index wins), x0 hardwired
// to zero, and a busy-bit scoreboard for multi-cycle producers.
// Optional macro RF_DEBUG_PORT_EN adds a lowest-priority debug access port
// (read has no bypass, write never touches busy bits).
module regfile_mp
    import rv100_pkg::*;
#(
    parameter int  XLEN  = rv100_pkg::XLEN,
    parameter int  NREGS = rv100_pkg::NREGS,
    parameter int  NRD   = 2,
    parameter int  NWR   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_rd,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic                dbg_en,
    input  logic                dbg_we,
    input  logic [AW-1:0]       dbg_addr,
    input  logic [XLEN-1:0]     dbg_wdata,
    output logic [XLEN-1:0]     dbg_rdata
`endif
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0]           wr_hit;
    logic [NREGS-1:0][XLEN-1:0] wr_val;

    // Resolve port writes per register; the ascending scan lets higher ports
    // override. Gated by rst_n so nothing bypasses while reset is held.
    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        for (int j = 0; j < NWR; j++) begin
            if (rst_n && wr_en[j] && wr_addr[j*AW +: AW] != AW'(REG_ZERO)) begin
                wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                wr_val[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            end
        end
    end

`ifdef RF_DEBUG_PORT_EN
    logic dbg_wr;
    assign dbg_wr    = dbg_en && dbg_we && dbg_addr != AW'(REG_ZERO);
    assign dbg_rdata = (dbg_addr == AW'(REG_ZERO)) ? '0 : regs_q[dbg_addr];
`endif

    // Register storage; x0 is only ever loaded by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= XLEN'(RF_RST_VAL);
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr_hit[r])
                    regs_q[r] <= wr_val[r];
`ifdef RF_DEBUG_PORT_EN
                else if (dbg_wr && dbg_addr == AW'(r))
                    regs_q[r] <= dbg_wdata;
`endif
            end
        end
    end

    // Read ports: zero for x0, same-cycle write data if any, else stored value.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[k*AW +: AW];
        assign rs_data[k*XLEN +: XLEN] = (a == AW'(REG_ZERO)) ? '0 :
                                         wr_hit[a]            ? wr_val[a] :
                                                                regs_q[a];
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .flush    (flush),
        .wr_hit   (wr_hit),
        .rs_addr  (rs_addr),
        .rs_busy  (rs_busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios followed by a randomized run,
// all checked against an array-based reference model of the register file.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_rd;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;
`ifdef RF_DEBUG_PORT_EN
    logic                dbg_en;
    logic                dbg_we;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_wdata;
    logic [XLEN-1:0]     dbg_rdata;
`endif

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .flush    (flush),
        .busy_vec (busy_vec)
`ifdef RF_DEBUG_PORT_EN
        ,
        .dbg_en    (dbg_en),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: architectural contents and pending-producer flags.
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_busy[NREGS];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [XLEN-1:0] rdp(int k);
        return rs_data[k*XLEN +: XLEN];
    endfunction

    task automatic set_rs(int k, int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(int j, bit en, int a, logic [XLEN-1:0] d);
        wr_en[j]               = en;
        wr_addr[j*AW +: AW]    = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        wr_en    = '0;
        alloc_en = 1'b0;
        alloc_rd = '0;
        flush    = 1'b0;
`ifdef RF_DEBUG_PORT_EN
        dbg_en   = 1'b0;
        dbg_we   = 1'b0;
`endif
    endtask

    function automatic void m_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    // Does any write port target register a this cycle? Last matching port wins.
    function automatic bit m_hit(int a, output logic [XLEN-1:0] v);
        bit h = 1'b0;
        v = '0;
        if (!rst_n || a == 0) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                h = 1'b1;
                v = wr_data[j*XLEN +: XLEN];
            end
        return h;
    endfunction

    function automatic logic [XLEN-1:0] m_rd(int a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        if (m_hit(a, v)) return v;
        return m_mem[a];
    endfunction

    function automatic bit m_rsbusy(int a);
        logic [XLEN-1:0] v;
        if (a == 0) return 1'b0;
        return m_busy[a] && !m_hit(a, v);
    endfunction

    function automatic logic [NREGS-1:0] m_busyvec();
        logic [NREGS-1:0] b = '0;
        for (int r = 1; r < NREGS; r++) b[r] = m_busy[r];
        return b;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void m_edge();
        bit              hit[NREGS];
        logic [XLEN-1:0] v;
        if (!rst_n) begin
            m_reset();
            return;
        end
        for (int r = 0; r < NREGS; r++) hit[r] = m_hit(r, v);
        for (int r = 1; r < NREGS; r++) begin
            if (flush)                               m_busy[r] = 1'b0;
            else if (alloc_en && int'(alloc_rd) == r) m_busy[r] = 1'b1;
            else if (hit[r])                         m_busy[r] = 1'b0;
        end
`ifdef RF_DEBUG_PORT_EN
        if (dbg_en && dbg_we && dbg_addr != 0) m_mem[dbg_addr] = dbg_wdata;
`endif
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
                m_mem[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    endfunction

    // Let combinational outputs settle mid-cycle and compare against the model.
    task automatic settle(string tag);
        #3;
        for (int k = 0; k < NRD; k++) begin
            int a = int'(rs_addr[k*AW +: AW]);
            chk({tag, "/rd"}, rdp(k), m_rd(a));
            chk({tag, "/rsbusy"}, 32'(rs_busy[k]), 32'(m_rsbusy(a)));
        end
`ifdef RF_DEBUG_PORT_EN
        chk({tag, "/dbg_rdata"}, dbg_rdata, (dbg_addr == 0) ? '0 : m_mem[dbg_addr]);
`endif
    endtask

    // Clock edge: model follows, then the registered busy vector is compared.
    task automatic commit(string tag);
        @(posedge clk);
        m_edge();
        #1;
        chk({tag, "/busy_vec"}, busy_vec, m_busyvec());
    endtask

    initial begin
        rst_n   = 1'b0;
        rs_addr = '0;
        wr_addr = '0;
        wr_data = '0;
`ifdef RF_DEBUG_PORT_EN
        dbg_addr  = '0;
        dbg_wdata = '0;
`endif
        idle();
        m_reset();
        #1;
        chk("rst_rd0", rdp(0), 32'h0);
        chk("rst_busy_vec", busy_vec, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bypass on read port 1, then stored value on the next cycle.
        set_wr(0, 1, 7, 32'h12345678);
        set_rs(1, 7);
        settle("byp");
        chk("byp_same", rdp(1), 32'h12345678);
        commit("byp");
        idle();
        settle("byp_next");
        chk("byp_next", rdp(1), 32'h12345678);

        // Two ports writing x3: port 1 wins both in bypass and in storage.
        set_wr(0, 1, 3, 32'h1);
        set_wr(1, 1, 3, 32'h2);
        set_rs(0, 3);
        settle("prio");
        chk("prio_byp", rdp(0), 32'h2);
        commit("prio");
        idle();
        settle("prio_st");
        chk("prio_stored", rdp(0), 32'h2);

        // x0: write and allocate are both ignored.
        set_wr(1, 1, 0, 32'hFFFFFFFF);
        alloc_en = 1'b1;
        alloc_rd = '0;
        set_rs(0, 0);
        settle("x0");
        chk("x0_byp", rdp(0), 32'h0);
        commit("x0");
        chk("x0_busy", 32'(busy_vec[0]), 32'h0);
        idle();
        settle("x0_st");
        chk("x0_stored", rdp(0), 32'h0);

        // Scoreboard: allocate, writeback clears, alloc beats write, flush clears all.
        alloc_en = 1'b1;
        alloc_rd = 5'd9;
        set_rs(0, 9);
        settle("sb_alloc");
        chk("sb_alloc_rsbusy_same", 32'(rs_busy[0]), 32'h0);
        commit("sb_alloc");
        chk("sb_alloc_vec", 32'(busy_vec[9]), 32'h1);
        idle();
        settle("sb_wait");
        chk("sb_rsbusy", 32'(rs_busy[0]), 32'h1);
        commit("sb_wait");
        set_wr(0, 1, 9, 32'hA5);
        settle("sb_wb");
        chk("sb_wb_rsbusy", 32'(rs_busy[0]), 32'h0);
        chk("sb_wb_byp", rdp(0), 32'hA5);
        commit("sb_wb");
        chk("sb_wb_vec", 32'(busy_vec[9]), 32'h0);
        idle();
        set_wr(0, 1, 9, 32'hB6);
        alloc_en = 1'b1;
        alloc_rd = 5'd9;
        commit("sb_allocwr");
        chk("sb_allocwr_vec", 32'(busy_vec[9]), 32'h1);
        idle();
        alloc_en = 1'b1;
        alloc_rd = 5'd12;
        commit("sb_alloc12");
        chk("sb_two_busy", busy_vec, 32'h0000_1200);
        idle();
        flush    = 1'b1;
        alloc_en = 1'b1;
        alloc_rd = 5'd11;
        commit("sb_flush");
        chk("sb_flush_vec", busy_vec, 32'h0);
        idle();

`ifdef RF_DEBUG_PORT_EN
        // Debug write loses to a port write on the same register.
        dbg_en    = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 5'd4;
        dbg_wdata = 32'h55;
        set_wr(0, 1, 4, 32'h66);
        commit("dbg_prio");
        idle();
        set_rs(0, 4);
        settle("dbg_prio");
        chk("dbg_prio_x4", rdp(0), 32'h66);
        alloc_en = 1'b1;
        alloc_rd = 5'd4;
        commit("dbg_alloc");
        idle();
        dbg_en    = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 5'd4;
        dbg_wdata = 32'h55;
        commit("dbg_wr");
        chk("dbg_busy_kept", 32'(busy_vec[4]), 32'h1);
        idle();
        dbg_en = 1'b1;
        settle("dbg_rd");
        chk("dbg_rdata_x4", dbg_rdata, 32'h55);
        idle();
        flush = 1'b1;
        commit("dbg_flush");
        idle();
`endif

        // Asynchronous reset mid-run wipes data and busy bits at once.
        set_wr(0, 1, 5, 32'hDEADBEEF);
        alloc_en = 1'b1;
        alloc_rd = 5'd6;
        commit("mr_wr");
        idle();
        set_rs(0, 5);
        settle("mr_pre");
        chk("mr_pre_x5", rdp(0), 32'hDEADBEEF);
        rst_n = 1'b0;
        set_wr(0, 1, 5, 32'h1111);
        #1;
        chk("mr_x5_now", rdp(0), 32'h0);
        chk("mr_busy_now", busy_vec, 32'h0);
        commit("mr_hold");
        chk("mr_x5_hold", rdp(0), 32'h0);
        idle();
        rst_n = 1'b1;
        settle("mr_post");
        chk("mr_x5_post", rdp(0), 32'h0);

        // Randomized traffic on a narrow register window to force collisions.
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < NWR; j++)
                set_wr(j, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            for (int k = 0; k < NRD; k++)
                set_rs(k, int'($urandom_range(0, 7)));
            alloc_en = ($urandom_range(0, 2) == 0);
            alloc_rd = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
`ifdef RF_DEBUG_PORT_EN
            dbg_en    = 1'($urandom_range(0, 1));
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = AW'($urandom_range(0, 7));
            dbg_wdata = $urandom;
`endif
            settle("rnd");
            commit("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
